// File: rtl/fsm_step_scheduler.sv
// Round-robin arbiter sharing one 4-state step sequencer between two requesters.
// Optional WAIT timeout with sticky err: define STEP_TIMEOUT_EN.
module fsm_step_scheduler #(
    parameter int STEP_W  = 3,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        req,
    input  logic [STEP_W-1:0] cnt0,
    input  logic [STEP_W-1:0] cnt1,
    input  logic [1:0]        fsm_state,
    output logic              step,
    output logic [1:0]        gnt,
    output logic [1:0]        done,
    output logic              busy,
    output logic              err
);

    typedef enum logic [1:0] {
        IDLE,
        STEP,
        WAIT,
        DONE
    } state_t;

    state_t            state;
    state_t            state_n;
    logic [STEP_W-1:0] rem;
    logic [STEP_W-1:0] rem_n;
    logic [1:0]        snap;
    logic [1:0]        snap_n;
    logic              rr_ptr;
    logic              rr_n;
    logic              gidx;
    logic              gidx_n;
    logic              step_n;
    logic [1:0]        gnt_n;
    logic [1:0]        done_n;
    logic              busy_n;

`ifdef STEP_TIMEOUT_EN
    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    logic [TW-1:0] tcnt;
    logic [TW-1:0] tcnt_n;
    logic          err_n;
`endif

    // Next-state, datapath and next-output decode.
    always_comb begin
        state_n = state;
        rem_n   = rem;
        snap_n  = snap;
        rr_n    = rr_ptr;
        gidx_n  = gidx;
`ifdef STEP_TIMEOUT_EN
        tcnt_n  = tcnt;
        err_n   = err;
`endif
        unique case (state)
            IDLE: begin
                if (req != 2'b00) begin
                    gidx_n  = (req == 2'b11) ? rr_ptr : req[1];
                    rem_n   = gidx_n ? cnt1 : cnt0;
                    snap_n  = fsm_state;
                    state_n = (rem_n == '0) ? DONE : STEP;
                end
            end
            STEP: begin
                state_n = WAIT;
`ifdef STEP_TIMEOUT_EN
                tcnt_n  = '0;
`endif
            end
            WAIT: begin
                if (fsm_state != snap) begin
                    snap_n = fsm_state;
                    if (rem != '0) begin
                        rem_n = rem - STEP_W'(1);
                    end
                    state_n = (rem_n == '0) ? DONE : STEP;
                end
`ifdef STEP_TIMEOUT_EN
                else if (tcnt == TW'(TIMEOUT - 1)) begin
                    rem_n   = '0;
                    err_n   = 1'b1;
                    state_n = DONE;
                end else begin
                    tcnt_n = tcnt + TW'(1);
                end
`endif
            end
            DONE: begin
                rr_n    = ~gidx;
                state_n = IDLE;
            end
        endcase

        step_n = (state_n == STEP);
        busy_n = (state_n != IDLE);
        gnt_n  = 2'b00;
        if (state_n != IDLE) begin
            gnt_n = gidx_n ? 2'b10 : 2'b01;
        end
        done_n = (state_n == DONE) ? gnt_n : 2'b00;
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            rem    <= '0;
            snap   <= 2'b00;
            rr_ptr <= 1'b0;
            gidx   <= 1'b0;
            step   <= 1'b0;
            gnt    <= 2'b00;
            done   <= 2'b00;
            busy   <= 1'b0;
        end else begin
            state  <= state_n;
            rem    <= rem_n;
            snap   <= snap_n;
            rr_ptr <= rr_n;
            gidx   <= gidx_n;
            step   <= step_n;
            gnt    <= gnt_n;
            done   <= done_n;
            busy   <= busy_n;
        end
    end

`ifdef STEP_TIMEOUT_EN
    // WAIT timeout counter and sticky error flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tcnt <= '0;
            err  <= 1'b0;
        end else begin
            tcnt <= tcnt_n;
            err  <= err_n;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule
